// File: rtl/systolic_mac_if.sv
// Operand-stream and result-drain signal bundle for the systolic MAC array.
// The master drives jobs and operands; the slave is the engine.
interface systolic_mac_if #(
   parameter int N          = 4,
   parameter int DATA_WIDTH = 8,
   parameter int K_WIDTH    = 9,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+K_WIDTH
);
   localparam int RW = (N > 1) ? $clog2(N) : 1;

   logic                    start;
   logic [K_WIDTH-1:0]      k_len;
   logic                    signed_mode;
   logic                    in_valid;
   logic                    in_ready;
   logic [N*DATA_WIDTH-1:0] a_col;
   logic [N*DATA_WIDTH-1:0] b_row;
   logic                    out_valid;
   logic                    out_ready;
   logic [N*ACC_WIDTH-1:0]  out_data;
   logic [RW-1:0]           out_row;
   logic                    busy;
   logic                    done;

   modport master (
      output start, k_len, signed_mode, in_valid, a_col, b_row, out_ready,
      input  in_ready, out_valid, out_data, out_row, busy, done
   );

   modport slave (
      input  start, k_len, signed_mode, in_valid, a_col, b_row, out_ready,
      output in_ready, out_valid, out_data, out_row, busy, done
   );
endinterface

// File: rtl/systolic_mac_array.sv
// NxN output-stationary systolic matrix multiply, C = A * B, with internal operand
// skewing, stallable operand stream and a row-by-row result drain.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; accumulators cleared when a job is accepted
// S_LOAD  | accepting K operand beats (in_ready=1)
// S_FLUSH | 2N-2 zero beats push the last operands through the array
// S_DRAIN | presenting result rows 0..N-1 under out_ready backpressure
module systolic_mac_array #(
   parameter int N          = 4,
   parameter int DATA_WIDTH = 8,
   parameter int K_WIDTH    = 9,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+K_WIDTH
) (
   input logic          clk,
   input logic          rst,
   systolic_mac_if.slave bus
);
   localparam int DW         = DATA_WIDTH;
   localparam int PW         = 2*DATA_WIDTH;
   localparam int RW         = (N > 1) ? $clog2(N) : 1;
   localparam int CW         = $clog2(2*N);
   localparam int FLUSH_LAST = (N > 1) ? 2*N-3 : 0;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

   state_t             state;
   logic               in_ready_q;
   logic               out_valid_q;
   logic [RW-1:0]      out_row_q;
   logic               busy_q;
   logic               done_q;
   logic [K_WIDTH-1:0] beat_cnt;
   logic [K_WIDTH-1:0] k_len_l;
   logic [CW-1:0]      flush_cnt;
   logic               signed_l;

   logic en;
   logic clr;

   logic [DW-1:0] a_inj [N];
   logic [DW-1:0] b_inj [N];

   wire [DW-1:0]        a_fwd [N][N];
   wire [DW-1:0]        b_fwd [N][N];
   wire [ACC_WIDTH-1:0] acc   [N][N];

   assign en  = ((state == S_LOAD) && bus.in_valid) || (state == S_FLUSH);
   // done_q blocks a start that arrives in the same cycle as the completion pulse
   assign clr = (state == S_IDLE) && bus.start && !done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         beat_cnt    <= '0;
         k_len_l     <= '0;
         flush_cnt   <= '0;
         signed_l    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (clr) begin
                  k_len_l   <= bus.k_len;
                  signed_l  <= bus.signed_mode;
                  beat_cnt  <= '0;
                  busy_q    <= 1'b1;
                  out_row_q <= '0;
                  if (bus.k_len == '0) begin
                     state       <= S_DRAIN;
                     out_valid_q <= 1'b1;
                  end else begin
                     state      <= S_LOAD;
                     in_ready_q <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (bus.in_valid) begin
                  beat_cnt <= beat_cnt + K_WIDTH'(1);
                  if (beat_cnt == k_len_l - K_WIDTH'(1)) begin
                     in_ready_q <= 1'b0;
                     if (N > 1) begin
                        state     <= S_FLUSH;
                        flush_cnt <= CW'(FLUSH_LAST);
                     end else begin
                        state       <= S_DRAIN;
                        out_valid_q <= 1'b1;
                     end
                  end
               end
            end
            S_FLUSH: begin
               if (flush_cnt == '0) begin
                  state       <= S_DRAIN;
                  out_valid_q <= 1'b1;
               end else begin
                  flush_cnt <= flush_cnt - CW'(1);
               end
            end
            S_DRAIN: begin
               if (bus.out_ready) begin
                  if (out_row_q == RW'(N-1)) begin
                     state       <= S_IDLE;
                     out_valid_q <= 1'b0;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     out_row_q   <= '0;
                  end else begin
                     out_row_q <= out_row_q + RW'(1);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_row   = out_row_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

   // Zeros are injected outside LOAD so the flush drains the array cleanly
   always_comb begin
      for (int i = 0; i < N; i++) begin
         a_inj[i] = (state == S_LOAD) ? bus.a_col[i*DW +: DW] : '0;
         b_inj[i] = (state == S_LOAD) ? bus.b_row[i*DW +: DW] : '0;
      end
   end

   // Row i of A and column i of B both need i stages of delay
   for (genvar i = 0; i < N; i++) begin : g_skew
      if (i == 0) begin : g_direct
         assign a_fwd[0][0] = a_inj[0];
         assign b_fwd[0][0] = b_inj[0];
      end else begin : g_stage
         logic [DW-1:0] a_sk [i];
         logic [DW-1:0] b_sk [i];
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int s = 0; s < i; s++) begin
                  a_sk[s] <= '0;
                  b_sk[s] <= '0;
               end
            end else if (en) begin
               a_sk[0] <= a_inj[i];
               b_sk[0] <= b_inj[i];
               for (int s = 1; s < i; s++) begin
                  a_sk[s] <= a_sk[s-1];
                  b_sk[s] <= b_sk[s-1];
               end
            end
         end
         assign a_fwd[i][0] = a_sk[i-1];
         assign b_fwd[0][i] = b_sk[i-1];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic [PW-1:0]        a_ext;
         logic [PW-1:0]        b_ext;
         logic [PW-1:0]        prod;
         logic [ACC_WIDTH-1:0] prod_ext;
         logic [ACC_WIDTH-1:0] acc_q;

         // Extending to PW before a PW-bit multiply gives the exact product in either mode
         always_comb begin
            a_ext    = {{DW{signed_l & a_fwd[i][j][DW-1]}}, a_fwd[i][j]};
            b_ext    = {{DW{signed_l & b_fwd[i][j][DW-1]}}, b_fwd[i][j]};
            prod     = a_ext * b_ext;
            prod_ext = {{(ACC_WIDTH-PW){signed_l & prod[PW-1]}}, prod};
         end

         always_ff @(posedge clk) begin
            if (rst || clr) begin
               acc_q <= '0;
            end else if (en) begin
               acc_q <= acc_q + prod_ext;
            end
         end
         assign acc[i][j] = acc_q;

         if (j < N-1) begin : g_apass
            logic [DW-1:0] a_q;
            always_ff @(posedge clk) begin
               if (rst) begin
                  a_q <= '0;
               end else if (en) begin
                  a_q <= a_fwd[i][j];
               end
            end
            assign a_fwd[i][j+1] = a_q;
         end

         if (i < N-1) begin : g_bpass
            logic [DW-1:0] b_q;
            always_ff @(posedge clk) begin
               if (rst) begin
                  b_q <= '0;
               end else if (en) begin
                  b_q <= b_fwd[i][j];
               end
            end
            assign b_fwd[i+1][j] = b_q;
         end
      end
   end

   always_comb begin
      bus.out_data = '0;
      for (int j = 0; j < N; j++) begin
         bus.out_data[j*ACC_WIDTH +: ACC_WIDTH] = acc[out_row_q][j];
      end
   end
endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed bench for systolic_mac_array: uniform-operand vector table plus
// hand sequences for input stalls, output backpressure, K=0 and mid-job reset.
module tb_systolic_mac_array;
   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int KW  = 9;
   localparam int ACC = 2*DW+KW;

   typedef struct {
      int         k;
      bit         sgn;
      logic [7:0] a;
      logic [7:0] b;
      logic [24:0] exp;
      int         lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   systolic_mac_if #(.N(N), .DATA_WIDTH(DW), .K_WIDTH(KW), .ACC_WIDTH(ACC)) bus ();

   systolic_mac_array #(.N(N), .DATA_WIDTH(DW), .K_WIDTH(KW), .ACC_WIDTH(ACC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]  a_m   [N][16];
   logic [7:0]  b_m   [16][N];
   logic [24:0] exp_c [N][N];
   int n_tests = 0;
   int n_fail  = 0;
   vec_t vecs [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fill_uniform(input int k, input logic [7:0] a, input logic [7:0] b,
                               input logic [24:0] e);
      for (int i = 0; i < N; i++)
         for (int kk = 0; kk < 16; kk++) begin
            a_m[i][kk] = a;
            b_m[kk][i] = b;
         end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            exp_c[i][j] = (k == 0) ? 25'd0 : e;
   endtask

   task automatic fill_random(input int k, input bit sgn);
      for (int i = 0; i < N; i++)
         for (int kk = 0; kk < 16; kk++) begin
            a_m[i][kk] = 8'($urandom);
            b_m[kk][i] = 8'($urandom);
         end
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            int s;
            s = 0;
            for (int kk = 0; kk < k; kk++) begin
               int av, bv;
               av = int'(a_m[i][kk]);
               bv = int'(b_m[kk][j]);
               if (sgn && av > 127) av -= 256;
               if (sgn && bv > 127) bv -= 256;
               s += av * bv;
            end
            exp_c[i][j] = s[24:0];
         end
   endtask

   // mode 0: in_valid always high; 1: random in_valid; 2: out_ready low 5 cycles on row 1
   task automatic do_job(input int k, input bit sgn, input int mode, input bit poke,
                         input int exp_lat);
      int cyc, bi, rows, first_v, done_cnt, stall, rdy_bad;
      bit iv, rdy_now;
      cyc = 0; bi = 0; rows = 0; first_v = -1; done_cnt = 0; stall = 0; rdy_bad = 0;
      bus.k_len = KW'(k);
      bus.signed_mode = sgn;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.k_len = KW'(5);
      bus.signed_mode = ~sgn;
      cyc = 1;
      while (done_cnt == 0 && cyc < 800) begin
         if (bus.out_valid && first_v < 0) first_v = cyc;
         if (bus.in_ready && bi >= k) rdy_bad++;
         bus.out_ready = 1'b1;
         if (mode == 2 && bus.out_valid && bus.out_row == 2'd1 && stall < 5) begin
            bus.out_ready = 1'b0;
            stall++;
            check("stall_row", 64'(bus.out_row), 64'd1);
            for (int j = 0; j < N; j++)
               check($sformatf("stall_lane%0d", j), 64'(bus.out_data[j*ACC +: ACC]),
                     64'(exp_c[1][j]));
         end
         if (bus.out_valid && bus.out_ready) begin
            check("row_order", 64'(bus.out_row), 64'(rows));
            if (rows < N)
               for (int j = 0; j < N; j++)
                  check($sformatf("k%0d_row%0d_lane%0d", k, rows, j),
                        64'(bus.out_data[j*ACC +: ACC]), 64'(exp_c[rows][j]));
            rows++;
         end
         bus.start = poke && bus.out_valid && rows == 1;
         iv = (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
         bus.in_valid = iv;
         for (int i = 0; i < N; i++) begin
            if (bi < k) begin
               bus.a_col[i*DW +: DW] = a_m[i][bi];
               bus.b_row[i*DW +: DW] = b_m[bi][i];
            end else begin
               bus.a_col[i*DW +: DW] = 8'hA5;
               bus.b_row[i*DW +: DW] = 8'h5A;
            end
         end
         rdy_now = bus.in_ready;
         @(posedge clk); #1;
         cyc++;
         if (iv && rdy_now) bi++;
         if (bus.done) done_cnt++;
      end
      check("done_seen", 64'(done_cnt), 64'd1);
      check("rows_delivered", 64'(rows), 64'(N));
      check("beats_consumed", 64'(bi), 64'(k));
      check("in_ready_outside_load", 64'(rdy_bad), 64'd0);
      if (exp_lat >= 0) check("latency", 64'(first_v), 64'(exp_lat));
      check("busy_at_done", 64'(bus.busy), 64'd0);
      bus.in_valid = 1'b0;
      bus.start = poke;
      bus.k_len = KW'(5);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("done_one_cycle", 64'(bus.done), 64'd0);
      check("idle_after_done", 64'(bus.in_ready), 64'd0);
      check("not_busy_after_done", 64'(bus.busy), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
      check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
      check({tag, "_out_row"}, 64'(bus.out_row), 64'd0);
      check({tag, "_busy"}, 64'(bus.busy), 64'd0);
      check({tag, "_done"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int done_bad;
      vecs[0] = '{10, 1'b1, 8'h01, 8'h01, 25'd10,       17};
      vecs[1] = '{3,  1'b1, 8'hFF, 8'h01, 25'h1FFFFFD,  10};
      vecs[2] = '{3,  1'b0, 8'hFF, 8'h01, 25'd765,      10};
      vecs[3] = '{5,  1'b1, 8'h80, 8'h80, 25'd81920,    12};
      vecs[4] = '{4,  1'b0, 8'hFF, 8'hFF, 25'd260100,   11};
      vecs[5] = '{1,  1'b1, 8'h7F, 8'h80, 25'h1FFC080,  8};
      vecs[6] = '{0,  1'b1, 8'h33, 8'h44, 25'd0,        1};

      rst = 1'b1;
      bus.start = 1'b0;
      bus.k_len = '0;
      bus.signed_mode = 1'b0;
      bus.in_valid = 1'b0;
      bus.a_col = '0;
      bus.b_row = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[v]) begin
         fill_uniform(vecs[v].k, vecs[v].a, vecs[v].b, vecs[v].exp);
         do_job(vecs[v].k, vecs[v].sgn, 0, 1'b0, vecs[v].lat);
      end

      // Random operands with in_valid bubbles, signed then unsigned
      fill_random(7, 1'b1);
      do_job(7, 1'b1, 1, 1'b0, -1);
      fill_random(7, 1'b0);
      do_job(7, 1'b0, 1, 1'b0, -1);

      // Output backpressure on row 1
      fill_random(7, 1'b1);
      do_job(7, 1'b1, 2, 1'b0, -1);

      // K=0 with start poked while busy and on the done cycle
      fill_uniform(0, 8'h11, 8'h22, 25'd0);
      do_job(0, 1'b0, 0, 1'b1, 1);

      // Reset in the middle of FLUSH
      bus.k_len = KW'(3);
      bus.signed_mode = 1'b1;
      bus.start = 1'b1;
      bus.in_valid = 1'b1;
      bus.a_col = {N{8'h01}};
      bus.b_row = {N{8'h01}};
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("flush_in_ready", 64'(bus.in_ready), 64'd0);
      check("flush_busy", 64'(bus.busy), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      check_reset_outputs("midjob_reset");
      done_bad = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus.done || bus.out_valid) done_bad++;
      end
      check("no_done_after_abort", 64'(done_bad), 64'd0);

      fill_uniform(2, 8'h02, 8'h02, 25'd8);
      do_job(2, 1'b1, 0, 1'b0, 9);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
